// File: rtl/reveal_engine_pkg.sv
// Shared definitions for the flood-fill reveal engine: cell field layout,
// FSM state encoding and the neighbour offset table.
package reveal_engine_pkg;

   localparam int CELL_MINE_BIT = 4;
   localparam int CELL_CNT_MSB  = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_EVAL  = 3'd3,
      ST_NEIGH = 3'd4,
      ST_OVER  = 3'd5
   } state_t;

   // Visit order: row above left-to-right, same row left/right, row below.
   localparam int NBR_DX [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};
   localparam int NBR_DY [8] = '{-1, -1, -1,  0, 0,  1, 1, 1};

endpackage

// File: rtl/reveal_engine_coord_stack.sv
// LIFO of packed cell coordinates for the flood fill; top is readable
// combinationally so a pop and its data land in the same cycle.
module reveal_engine_coord_stack #(
   parameter int depth = 256,
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] din,
   output logic [width-1:0] top,
   output logic             empty
);
   localparam int AW = $clog2(depth);
   localparam int PW = $clog2(depth + 1);

   logic [width-1:0] mem [depth];
   logic [PW-1:0]    sp_reg;
   logic [AW-1:0]    top_addr;

   assign top_addr = sp_reg[AW-1:0] - AW'(1);
   assign top      = mem[top_addr];
   assign empty    = (sp_reg == '0);

   // Push together with pop overwrites the popped slot (pop-then-push).
   always_ff @(posedge clk) begin
      if (push)
         mem[pop ? top_addr : sp_reg[AW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (!reset)
         sp_reg <= '0;
      else if (push && !pop)
         sp_reg <= sp_reg + PW'(1);
      else if (pop && !push)
         sp_reg <= sp_reg - PW'(1);
   end

endmodule

// File: rtl/reveal_engine.sv
// Flood-fill reveal controller: reads cells from the board, tracks the
// revealed bitmap and auto-reveals neighbours of zero-count cells.
module reveal_engine
   import reveal_engine_pkg::*;
#(
   parameter int x_size       = 16,
   parameter int y_size       = 16,
   parameter int x_coord_bits = 4,
   parameter int y_coord_bits = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                clear,
   input  logic                                is_init,
   input  logic                                start,
   input  logic [x_coord_bits-1:0]             start_x,
   input  logic [y_coord_bits-1:0]             start_y,
   input  logic [x_coord_bits+y_coord_bits-1:0] num_mines,
   output logic [x_coord_bits-1:0]             rd_x,
   output logic [y_coord_bits-1:0]             rd_y,
   input  logic [4:0]                          rd_val,
   input  logic [x_coord_bits-1:0]             q_x,
   input  logic [y_coord_bits-1:0]             q_y,
   output logic                                q_revealed,
   output logic                                busy,
   output logic                                done,
   output logic                                hit_mine,
   output logic                                won,
   output logic [x_coord_bits+y_coord_bits:0]  revealed_count
);
   localparam int CELLS = x_size * y_size;
   localparam int IW    = $clog2(CELLS);
   localparam int SW    = x_coord_bits + y_coord_bits;
   localparam int CW    = SW + 1;
   localparam int XW    = x_coord_bits + 1;
   localparam int YW    = y_coord_bits + 1;

   function automatic logic [IW-1:0] cell_idx(input logic [x_coord_bits-1:0] x,
                                               input logic [y_coord_bits-1:0] y);
      return IW'(int'(y) * x_size + int'(x));
   endfunction

   state_t                  state_reg, state_next;
   logic [CELLS-1:0]        bitmap_reg, bitmap_next;
   logic [CW-1:0]           count_reg, count_next;
   logic [x_coord_bits-1:0] rd_x_reg, rd_x_next;
   logic [y_coord_bits-1:0] rd_y_reg, rd_y_next;
   logic [2:0]              nbr_reg, nbr_next;
   logic                    busy_reg, busy_next;
   logic                    done_reg, done_next;
   logic                    hit_reg, hit_next;
   logic                    won_reg, won_next;

   logic          push, pop, stack_empty, stack_reset;
   logic [SW-1:0] push_data, stack_top;
   logic [XW-1:0] nx;
   logic [YW-1:0] ny;
   logic          n_in;
   logic [CW-1:0] win_target;

   assign stack_reset = reset & ~clear;

   reveal_engine_coord_stack #(.depth(CELLS), .width(SW)) u_stack (
      .clk   (clk),
      .reset (stack_reset),
      .push  (push),
      .pop   (pop),
      .din   (push_data),
      .top   (stack_top),
      .empty (stack_empty)
   );

   // One extra bit makes -1 wrap to a large value, so a single upper-bound
   // compare rejects both underflow and overflow.
   assign nx         = XW'(int'(rd_x_reg) + NBR_DX[nbr_reg]);
   assign ny         = YW'(int'(rd_y_reg) + NBR_DY[nbr_reg]);
   assign n_in       = (int'(nx) < x_size) && (int'(ny) < y_size);
   assign win_target = CW'(CELLS) - CW'(num_mines);

   always_comb begin
      state_next  = state_reg;
      bitmap_next = bitmap_reg;
      count_next  = count_reg;
      rd_x_next   = rd_x_reg;
      rd_y_next   = rd_y_reg;
      nbr_next    = nbr_reg;
      busy_next   = busy_reg;
      done_next   = 1'b0;
      hit_next    = hit_reg;
      won_next    = won_reg | (!hit_reg && count_reg == win_target);
      push        = 1'b0;
      pop         = 1'b0;
      push_data   = {start_y, start_x};
      case (state_reg)
         ST_IDLE: begin
            if (start && is_init && !hit_reg && !won_reg &&
                !bitmap_reg[cell_idx(start_x, start_y)]) begin
               bitmap_next[cell_idx(start_x, start_y)] = 1'b1;
               count_next = count_reg + CW'(1);
               push       = 1'b1;
               busy_next  = 1'b1;
               state_next = ST_POP;
            end
         end
         ST_POP: begin
            pop        = 1'b1;
            rd_x_next  = stack_top[x_coord_bits-1:0];
            rd_y_next  = stack_top[SW-1:x_coord_bits];
            state_next = ST_WAIT;
         end
         ST_WAIT: state_next = ST_EVAL;
         ST_EVAL: begin
            if (rd_val[CELL_MINE_BIT]) begin
               hit_next   = 1'b1;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = ST_OVER;
            end else if (rd_val[CELL_CNT_MSB:0] == '0) begin
               nbr_next   = '0;
               state_next = ST_NEIGH;
            end else if (stack_empty) begin
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = ST_IDLE;
            end else begin
               state_next = ST_POP;
            end
         end
         ST_NEIGH: begin
            push_data = {ny[y_coord_bits-1:0], nx[x_coord_bits-1:0]};
            if (n_in && !bitmap_reg[cell_idx(nx[x_coord_bits-1:0], ny[y_coord_bits-1:0])]) begin
               bitmap_next[cell_idx(nx[x_coord_bits-1:0], ny[y_coord_bits-1:0])] = 1'b1;
               count_next = count_reg + CW'(1);
               push       = 1'b1;
            end
            nbr_next = nbr_reg + 3'd1;
            if (nbr_reg == 3'd7) begin
               if (stack_empty && !push) begin
                  done_next  = 1'b1;
                  busy_next  = 1'b0;
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_POP;
               end
            end
         end
         ST_OVER: busy_next = 1'b0;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         state_reg  <= ST_IDLE;
         bitmap_reg <= '0;
         count_reg  <= '0;
         rd_x_reg   <= '0;
         rd_y_reg   <= '0;
         nbr_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         hit_reg    <= 1'b0;
         won_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         bitmap_reg <= bitmap_next;
         count_reg  <= count_next;
         rd_x_reg   <= rd_x_next;
         rd_y_reg   <= rd_y_next;
         nbr_reg    <= nbr_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
         hit_reg    <= hit_next;
         won_reg    <= won_next;
      end
   end

   assign rd_x           = rd_x_reg;
   assign rd_y           = rd_y_reg;
   assign q_revealed     = bitmap_reg[cell_idx(q_x, q_y)];
   assign busy           = busy_reg;
   assign done           = done_reg;
   assign hit_mine       = hit_reg;
   assign won            = won_reg;
   assign revealed_count = count_reg;

endmodule

// File: tb/tb_reveal_engine.sv
// Directed bench for reveal_engine with a 1-cycle-latency board model.
module tb_reveal_engine;

   logic       clk = 1'b0;
   logic       reset, clear, is_init, start;
   logic [3:0] start_x, start_y, rd_x, rd_y, q_x, q_y;
   logic [7:0] num_mines;
   logic [4:0] rd_val;
   logic       q_revealed, busy, done, hit_mine, won;
   logic [8:0] revealed_count;

   int checks = 0;
   int errors = 0;

   logic       mine_map [16][16];
   logic [4:0] board    [16][16];

   always #5 clk = ~clk;

   always @(posedge clk) rd_val <= board[rd_y][rd_x];

   reveal_engine dut (
      .clk(clk), .reset(reset), .clear(clear), .is_init(is_init), .start(start),
      .start_x(start_x), .start_y(start_y), .num_mines(num_mines),
      .rd_x(rd_x), .rd_y(rd_y), .rd_val(rd_val), .q_x(q_x), .q_y(q_y),
      .q_revealed(q_revealed), .busy(busy), .done(done), .hit_mine(hit_mine),
      .won(won), .revealed_count(revealed_count)
   );

   typedef struct {
      logic init;
      int   x;
      int   y;
      logic exp_done;
      int   exp_count;
      logic exp_hit;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic build_board();
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++) begin
            int n = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  if ((dx != 0 || dy != 0) && x+dx >= 0 && x+dx < 16 && y+dy >= 0 && y+dy < 16)
                     if (mine_map[y+dy][x+dx]) n++;
            board[y][x] = mine_map[y][x] ? 5'h10 : 5'(n);
         end
   endtask

   task automatic clear_mines();
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            mine_map[y][x] = 1'b0;
   endtask

   task automatic pulse_start(input int x, input int y);
      @(posedge clk); #1;
      start_x = 4'(x);
      start_y = 4'(y);
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = -1;
      for (int c = 1; c <= limit; c++) begin
         @(posedge clk); #1;
         if (done) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic query(input int x, input int y, output int r);
      q_x = 4'(x);
      q_y = 4'(y);
      #1 r = int'(q_revealed);
   endtask

   task automatic scan(output int n);
      n = 0;
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++) begin
            q_x = 4'(x);
            q_y = 4'(y);
            #1 n += int'(q_revealed);
         end
      @(posedge clk); #1;
   endtask

   initial begin
      int cyc, r, n;
      reset = 1'b0; clear = 1'b0; is_init = 1'b0; start = 1'b0;
      start_x = '0; start_y = '0; q_x = '0; q_y = '0; num_mines = '0;
      clear_mines();
      build_board();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_count", int'(revealed_count), 0);
      chk("reset_hit", int'(hit_mine), 0);
      chk("reset_won", int'(won), 0);
      scan(n);
      chk("reset_bitmap", n, 0);

      // Board 1: mines at (2,2), (4,2), (5,5); (3,3) and (3,1) both read 2.
      mine_map[2][2] = 1'b1;
      mine_map[2][4] = 1'b1;
      mine_map[5][5] = 1'b1;
      build_board();
      num_mines = 8'd3;
      is_init   = 1'b1;
      chk("board_model_33", int'(board[3][3]), 2);

      // Exact latency for a single non-zero cell.
      pulse_start(3, 3);
      chk("lat_e0_done", int'(done), 0);
      chk("lat_e0_busy", int'(busy), 1);
      @(posedge clk); #1;
      chk("lat_e1_done", int'(done), 0);
      @(posedge clk); #1;
      chk("lat_e2_done", int'(done), 0);
      @(posedge clk); #1;
      chk("lat_e3_done", int'(done), 1);
      chk("lat_e3_busy", int'(busy), 0);
      chk("lat_count", int'(revealed_count), 1);
      @(posedge clk); #1;
      chk("lat_e4_done", int'(done), 0);
      query(3, 3, r);
      chk("q_3_3", r, 1);
      query(3, 4, r);
      chk("q_3_4", r, 0);
      $display("single cell (3,3) count=%0d", revealed_count);

      pulse_clear();
      chk("clear_count", int'(revealed_count), 0);

      vecs[0] = '{init: 1'b0, x: 3, y: 3, exp_done: 1'b0, exp_count: 0, exp_hit: 1'b0};
      vecs[1] = '{init: 1'b1, x: 3, y: 3, exp_done: 1'b1, exp_count: 1, exp_hit: 1'b0};
      vecs[2] = '{init: 1'b1, x: 3, y: 3, exp_done: 1'b0, exp_count: 1, exp_hit: 1'b0};
      vecs[3] = '{init: 1'b1, x: 3, y: 1, exp_done: 1'b1, exp_count: 2, exp_hit: 1'b0};
      vecs[4] = '{init: 1'b1, x: 5, y: 5, exp_done: 1'b1, exp_count: 3, exp_hit: 1'b1};
      vecs[5] = '{init: 1'b1, x: 0, y: 0, exp_done: 1'b0, exp_count: 3, exp_hit: 1'b1};

      for (int i = 0; i < 6; i++) begin
         is_init = vecs[i].init;
         pulse_start(vecs[i].x, vecs[i].y);
         wait_done(20, cyc);
         chk($sformatf("vec%0d_done", i), int'(cyc >= 0), int'(vecs[i].exp_done));
         if (vecs[i].exp_done)
            chk($sformatf("vec%0d_latency", i), cyc, 3);
         chk($sformatf("vec%0d_count", i), int'(revealed_count), vecs[i].exp_count);
         chk($sformatf("vec%0d_hit", i), int'(hit_mine), int'(vecs[i].exp_hit));
         chk($sformatf("vec%0d_busy", i), int'(busy), 0);
         $display("vec %0d start=(%0d,%0d) init=%0d done_cyc=%0d count=%0d hit=%0d",
                  i, vecs[i].x, vecs[i].y, vecs[i].init, cyc, revealed_count, hit_mine);
      end
      is_init = 1'b1;

      // Board 2: single mine in the corner; a start at (0,0) floods everything else.
      clear_mines();
      mine_map[15][15] = 1'b1;
      build_board();
      num_mines = 8'd1;
      pulse_clear();
      chk("clear_after_hit", int'(hit_mine), 0);

      pulse_start(0, 0);
      repeat (10) @(posedge clk);
      #1 chk("flood_busy", int'(busy), 1);
      pulse_start(15, 15);
      wait_done(6000, cyc);
      chk("flood_done_seen", int'(cyc >= 0), 1);
      @(posedge clk); #1;
      chk("flood_count", int'(revealed_count), 255);
      chk("flood_won", int'(won), 1);
      chk("flood_hit", int'(hit_mine), 0);
      query(15, 15, r);
      chk("flood_q_15_15", r, 0);
      query(14, 14, r);
      chk("flood_q_14_14", r, 1);
      scan(n);
      chk("flood_bitmap", n, 255);
      $display("flood from (0,0) count=%0d won=%0d", revealed_count, won);

      pulse_start(15, 15);
      wait_done(20, cyc);
      chk("after_win_ignored", int'(cyc >= 0), 0);
      chk("after_win_hit", int'(hit_mine), 0);

      pulse_clear();
      chk("clear_won", int'(won), 0);
      chk("clear_count2", int'(revealed_count), 0);
      scan(n);
      chk("clear_bitmap", n, 0);
      $display("clear after win count=%0d won=%0d", revealed_count, won);

      // Reset in the middle of a flood.
      pulse_start(0, 0);
      repeat (100) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_count", int'(revealed_count), 0);
      chk("midreset_done", int'(done), 0);
      scan(n);
      chk("midreset_bitmap", n, 0);
      pulse_start(0, 0);
      wait_done(6000, cyc);
      chk("refill_done_seen", int'(cyc >= 0), 1);
      @(posedge clk); #1;
      chk("refill_count", int'(revealed_count), 255);
      chk("refill_won", int'(won), 1);
      $display("refill after reset count=%0d won=%0d", revealed_count, won);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
